master_seq: RTL and testbench
=============================

MASTER_SEQ -- requirements
Module: master_seq

Interface
REQ-001 Parameter ADDR_W, 32, address width in bits.
REQ-002 Parameter DATA_W, 32, write/read data width in bits.
REQ-003 Parameter DEPTH, 8, command queue entries; power of two, >=2.
REQ-004 Parameter TIMEOUT, 255, maximum cycles req may wait for ack; >=1.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 arst  in  1  reset, synchronous, active-high.
REQ-007 i_test_load  in  1  one-cycle strobe; pushes {i_test_cmd, i_test_addr, i_test_wdata} into queue.
REQ-008 i_test_cmd  in  1  1 = write, 0 = read.
REQ-009 i_test_addr  in  ADDR_W  command address.
REQ-010 i_test_wdata  in  DATA_W  command write data.
REQ-011 i_test_enable  in  1  level; 1 allows queued commands to be issued.
REQ-012 ack  in  1  slave acknowledge, sampled only while req=1.
REQ-013 rdata  in  DATA_W  slave read data, valid with ack.
REQ-014 req  out  1  bus request.
REQ-015 cmd  out  1  bus command.
REQ-016 addr  out  ADDR_W  bus address.
REQ-017 wdata  out  DATA_W  bus write data.
REQ-018 rd_data  out  DATA_W  captured read data.
REQ-019 rd_valid  out  1  one-cycle pulse, rd_data updated.
REQ-020 full  out  1  queue holds DEPTH entries.
REQ-021 empty  out  1  queue holds 0 entries.
REQ-022 ovf  out  1  sticky: a load was dropped.
REQ-023 tmo  out  1  sticky: a transaction timed out.
REQ-024 done_cnt  out  16  completed (acked) transactions, wraps at 65535->0.

Function
REQ-025 States IDLE, REQ; IDLE->REQ when i_test_enable=1 and empty=0 at an edge; cmd/addr/wdata load from queue head at that edge, req=1 after it.
REQ-026 In REQ, req, cmd, addr, wdata SHALL stay stable until the exit edge.
REQ-027 REQ->IDLE on the edge sampling ack=1: head popped, req=0, done_cnt+1.
REQ-028 On that edge with cmd=0, rd_data<=rdata and rd_valid=1 for exactly the next cycle; writes never pulse rd_valid.
REQ-029 req SHALL be low for at least one cycle between transactions; back-to-back throughput one transaction per 2 cycles with immediate ack.
REQ-030 Deasserting i_test_enable in REQ does not abort; current transaction completes, no new issue.
REQ-031 Load when full: entry dropped, ovf<=1, queue unchanged, even if a pop occurs same edge.
REQ-032 Load and pop same edge when not full: both take effect, occupancy unchanged.
REQ-033 Load into empty queue is issuable at the following edge (no bypass).
REQ-034 addr/wdata/cmd retain last values in IDLE.

Reset
REQ-035 arst=1 at an edge: state IDLE, queue flushed (empty=1, full=0), req=0, cmd=0, addr=0, wdata=0, rd_data=0, rd_valid=0, ovf=0, tmo=0, done_cnt=0; applies mid-transaction, ack ignored that edge.

Configuration
REQ-036 Macro MASTER_SEQ_TIMEOUT_EN defined: cycle counter runs in REQ; if ack absent for TIMEOUT consecutive REQ cycles, exit to IDLE at that edge, pop head, tmo<=1, done_cnt unchanged, no rd_valid.
REQ-037 Macro undefined: no counter, req waits indefinitely for ack, tmo tied 0.

Structure
REQ-038 Package master_seq_pkg holds state enum, CMD_READ=0/CMD_WRITE=1 constants and queue-entry struct type.
REQ-039 Sub-module master_seq_fifo implements the synchronous queue (push, pop, full, empty, head).

Verification
REQ-040 Load write 0x10/0xAAAA5555, enable, ack on 2nd req cycle -> req high 2 cycles, addr=0x10, wdata=0xAAAA5555, done_cnt=1, rd_valid never 1.
REQ-041 Load read 0x20, ack with rdata=0x12345678 -> rd_valid one cycle, rd_data=0x12345678.
REQ-042 Load 9 commands with DEPTH=8, enable=0 -> full=1 after 8th, ovf=1, exactly 8 transactions after enable.
REQ-043 Timeout build, TIMEOUT=4, ack never -> req high exactly 4 cycles, tmo=1, next command issued after 1 idle cycle.
REQ-044 arst asserted during REQ with 3 queued -> next cycle req=0, empty=1, done_cnt=0; no issue after reset release.
REQ-045 Drop enable while req waiting, ack 3 cycles later -> transaction completes, no further req.

Source files
------------

// File: rtl/master_seq_pkg.sv
// Shared types and constants for the master_seq command sequencer.
package master_seq_pkg;

  localparam int unsigned ENTRY_ADDR_W = 32;
  localparam int unsigned ENTRY_DATA_W = 32;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } state_t;

  typedef struct packed {
    logic                    cmd;
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] wdata;
  } entry_t;

endpackage

// File: rtl/master_seq_if.sv
// Request/acknowledge bus between the sequencer (master) and a slave.
interface master_seq_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              cmd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, cmd, addr, wdata, input ack, rdata);
  modport slave  (input req, cmd, addr, wdata, output ack, rdata);
endinterface

// File: rtl/master_seq_fifo.sv
// Synchronous command queue; pushes while full are ignored, pops while empty are ignored.
module master_seq_fifo
  import master_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic   clk,
  input  logic   arst,
  input  logic   i_push,
  input  logic   i_pop,
  input  entry_t i_data,
  output entry_t o_head,
  output logic   o_full,
  output logic   o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (arst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/master_seq.sv
// Queued bus master: issues loaded read/write commands over a req/ack bus.
// Optional ack timeout enabled by defining MASTER_SEQ_TIMEOUT_EN.
module master_seq
  import master_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = ENTRY_ADDR_W,
  parameter int unsigned DATA_W  = ENTRY_DATA_W,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              i_test_load,
  input  logic              i_test_cmd,
  input  logic [ADDR_W-1:0] i_test_addr,
  input  logic [DATA_W-1:0] i_test_wdata,
  input  logic              i_test_enable,
  master_seq_if.master      bus,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              tmo,
  output logic [15:0]       done_cnt
);

  state_t            r_state;
  logic              r_req;
  logic              r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_ovf;
  logic [15:0]       r_done;

  entry_t            w_push_entry;
  entry_t            w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_tmo_hit;

  assign w_push_entry = '{cmd:   i_test_cmd,
                          addr:  ENTRY_ADDR_W'(i_test_addr),
                          wdata: ENTRY_DATA_W'(i_test_wdata)};
  assign w_pop = (r_state == ST_REQ) && (bus.ack || w_tmo_hit);

  master_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .arst    (arst),
    .i_push  (i_test_load),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef MASTER_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_wait;
  logic             r_tmo;

  // r_wait counts completed no-ack REQ cycles; the TIMEOUT-th one exits.
  assign w_tmo_hit = (r_state == ST_REQ) && !bus.ack && (r_wait == CNT_W'(TIMEOUT - 1));
  assign tmo       = r_tmo;

  always_ff @(posedge clk) begin
    if (arst) begin
      r_wait <= '0;
      r_tmo  <= 1'b0;
    end else begin
      if (r_state == ST_REQ && !bus.ack) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
      if (w_tmo_hit) begin
        r_tmo <= 1'b1;
      end
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign tmo       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state    <= ST_IDLE;
      r_req      <= 1'b0;
      r_cmd      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_done     <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_test_enable && !w_empty) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_cmd   <= w_head.cmd;
            r_addr  <= ADDR_W'(w_head.addr);
            r_wdata <= DATA_W'(w_head.wdata);
          end
        end
        ST_REQ: begin
          if (bus.ack) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_done  <= r_done + 16'd1;
            if (r_cmd == CMD_READ) begin
              r_rd_data  <= bus.rdata;
              r_rd_valid <= 1'b1;
            end
          end else if (w_tmo_hit) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
          end
        end
      endcase
      // A load against a full queue is lost even when a pop frees a slot this edge.
      if (i_test_load && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.req   = r_req;
  assign bus.cmd   = r_cmd;
  assign bus.addr  = r_addr;
  assign bus.wdata = r_wdata;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign full      = w_full;
  assign empty     = w_empty;
  assign ovf       = r_ovf;
  assign done_cnt  = r_done;

endmodule

// File: tb/tb_master_seq.sv
// Self-checking bench for master_seq: directed vector table, corner sequences, random vs queue model.
`timescale 1ns/1ps
module tb_master_seq;
  import master_seq_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 4;

  logic          clk = 1'b0;
  logic          arst;
  logic          ld;
  logic          lcmd;
  logic [AW-1:0] laddr;
  logic [DW-1:0] lwdata;
  logic          en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          tmo;
  logic [15:0]   done_cnt;

  master_seq_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  master_seq #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .i_test_load   (ld),
    .i_test_cmd    (lcmd),
    .i_test_addr   (laddr),
    .i_test_wdata  (lwdata),
    .i_test_enable (en),
    .bus           (bus),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .full          (full),
    .empty         (empty),
    .ovf           (ovf),
    .tmo           (tmo),
    .done_cnt      (done_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1; ld = 1'b0; en = 1'b0; bus.ack = 1'b0; bus.rdata = '0;
    tick();
    arst = 1'b0;
  endtask

  // Transaction-level reference model: a queue of pending commands plus the one in flight.
  typedef struct { logic c; logic [31:0] a; logic [31:0] w; } ent_t;
  ent_t        mq[$];
  ent_t        mcur;
  bit          mbusy;
  int          mwait;
  int          m_done;
  bit          m_ovf, m_tmo, m_rdv;
  logic [31:0] m_rdd;

  task automatic model_update();
    bit popped;
    bit was_full;
    int sz0;
    if (arst) begin
      mq.delete(); mcur = '{1'b0, '0, '0}; mbusy = 0; mwait = 0;
      m_done = 0; m_ovf = 0; m_tmo = 0; m_rdv = 0; m_rdd = '0;
      return;
    end
    popped = 0;
    sz0 = mq.size();
    was_full = (sz0 == DEPTH);
    m_rdv = 0;
    if (mbusy) begin
      if (bus.ack) begin
        m_done = (m_done + 1) % 65536;
        if (mcur.c == 1'b0) begin m_rdd = bus.rdata; m_rdv = 1; end
        mbusy = 0; popped = 1;
      end else begin
        mwait++;
`ifdef MASTER_SEQ_TIMEOUT_EN
        if (mwait == TMO) begin m_tmo = 1; mbusy = 0; popped = 1; end
`endif
      end
    end else if (en && sz0 > 0) begin
      mcur = mq[0]; mbusy = 1; mwait = 0;
    end
    if (popped) void'(mq.pop_front());
    if (ld) begin
      if (was_full) m_ovf = 1;
      else mq.push_back('{lcmd, laddr, lwdata});
    end
  endtask

  task automatic compare_all();
    chk("rnd.req",      bus.req,   mbusy);
    chk("rnd.cmd",      bus.cmd,   mcur.c);
    chk("rnd.addr",     bus.addr,  mcur.a);
    chk("rnd.wdata",    bus.wdata, mcur.w);
    chk("rnd.rd_data",  rd_data,   m_rdd);
    chk("rnd.rd_valid", rd_valid,  m_rdv);
    chk("rnd.full",     full,      mq.size() == DEPTH);
    chk("rnd.empty",    empty,     mq.size() == 0);
    chk("rnd.ovf",      ovf,       m_ovf);
    chk("rnd.tmo",      tmo,       m_tmo);
    chk("rnd.done_cnt", done_cnt,  m_done);
  endtask

  typedef struct {
    logic ld, c; logic [31:0] a, w; logic en, ack; logic [31:0] rdat;
    logic e_req, e_cmd; logic [31:0] e_addr, e_wdata; logic e_rdv;
    logic [31:0] e_rdd; logic e_empty; int e_done;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int   n_tx;
    logic prev_req;
    logic exp_req;

    arst = 1'b1; ld = 1'b0; lcmd = 1'b0; laddr = '0; lwdata = '0; en = 1'b0;
    bus.ack = 1'b0; bus.rdata = '0;
    tick(); tick();
    arst = 1'b0;

    chk("rst.req",      bus.req,   0);
    chk("rst.cmd",      bus.cmd,   0);
    chk("rst.addr",     bus.addr,  0);
    chk("rst.wdata",    bus.wdata, 0);
    chk("rst.rd_data",  rd_data,   0);
    chk("rst.rd_valid", rd_valid,  0);
    chk("rst.empty",    empty,     1);
    chk("rst.full",     full,      0);
    chk("rst.ovf",      ovf,       0);
    chk("rst.tmo",      tmo,       0);
    chk("rst.done_cnt", done_cnt,  0);

    // Write 0x10 acked on its 2nd req cycle, then a read of 0x20 returning 0x12345678.
    tbl[0] = '{1, 1, 32'h10, 32'hAAAA5555, 0, 0, 0,  0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 0};
    tbl[1] = '{0, 0, 32'h0,  32'h0,        1, 0, 0,  1, 1, 32'h10, 32'hAAAA5555, 0, 32'h0,        0, 0};
    tbl[2] = '{0, 0, 32'h0,  32'h0,        1, 0, 0,  1, 1, 32'h10, 32'hAAAA5555, 0, 32'h0,        0, 0};
    tbl[3] = '{0, 0, 32'h0,  32'h0,        1, 1, 0,  0, 1, 32'h10, 32'hAAAA5555, 0, 32'h0,        1, 1};
    tbl[4] = '{1, 0, 32'h20, 32'h0,        1, 0, 0,  0, 1, 32'h10, 32'hAAAA5555, 0, 32'h0,        0, 1};
    tbl[5] = '{0, 0, 32'h0,  32'h0,        1, 0, 0,  1, 0, 32'h20, 32'h0,        0, 32'h0,        0, 1};
    tbl[6] = '{0, 0, 32'h0,  32'h0,        1, 1, 32'h12345678,
                                                     0, 0, 32'h20, 32'h0,        1, 32'h12345678, 1, 2};
    tbl[7] = '{0, 0, 32'h0,  32'h0,        1, 0, 0,  0, 0, 32'h20, 32'h0,        0, 32'h12345678, 1, 2};
    for (int i = 0; i < 8; i++) begin
      ld = tbl[i].ld; lcmd = tbl[i].c; laddr = tbl[i].a; lwdata = tbl[i].w;
      en = tbl[i].en; bus.ack = tbl[i].ack; bus.rdata = tbl[i].rdat;
      tick();
      chk($sformatf("vec%0d.req", i),      bus.req,   tbl[i].e_req);
      chk($sformatf("vec%0d.cmd", i),      bus.cmd,   tbl[i].e_cmd);
      chk($sformatf("vec%0d.addr", i),     bus.addr,  tbl[i].e_addr);
      chk($sformatf("vec%0d.wdata", i),    bus.wdata, tbl[i].e_wdata);
      chk($sformatf("vec%0d.rd_valid", i), rd_valid,  tbl[i].e_rdv);
      chk($sformatf("vec%0d.rd_data", i),  rd_data,   tbl[i].e_rdd);
      chk($sformatf("vec%0d.empty", i),    empty,     tbl[i].e_empty);
      chk($sformatf("vec%0d.done", i),     done_cnt,  tbl[i].e_done);
    end
    ld = 0; bus.ack = 0; bus.rdata = '0;

    // Nine loads into an eight-deep queue, then drain with ack held high.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ld = 1; lcmd = 1; laddr = i; lwdata = 32'h100 + i;
      tick();
      if (i == 7) begin chk("fill8.full", full, 1); chk("fill8.ovf", ovf, 0); end
      if (i == 8) begin chk("fill9.full", full, 1); chk("fill9.ovf", ovf, 1); end
    end
    ld = 0; en = 1; bus.ack = 1;
    n_tx = 0; prev_req = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.req && !prev_req) n_tx++;
      prev_req = bus.req;
    end
    chk("drain.tx_count", n_tx, 8);
    chk("drain.done_cnt", done_cnt, 8);
    chk("drain.empty", empty, 1);
    chk("drain.last_addr", bus.addr, 7);
    bus.ack = 0;

    // Reset while a transaction is waiting, with ack high on the reset edge.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ld = 1; lcmd = 0; laddr = 32'h40 + i; lwdata = '0;
      tick();
    end
    ld = 0; en = 1;
    tick();
    chk("midrst.req_before", bus.req, 1);
    arst = 1; bus.ack = 1;
    tick();
    arst = 0; bus.ack = 0;
    chk("midrst.req", bus.req, 0);
    chk("midrst.empty", empty, 1);
    chk("midrst.done_cnt", done_cnt, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("midrst.no_issue%0d", k), bus.req, 0);
    end

    // Enable dropped while waiting: the pending transaction still completes.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      ld = 1; lcmd = 1; laddr = 32'h80 + i; lwdata = 32'h55;
      tick();
    end
    ld = 0; en = 1;
    tick();
    chk("endrop.req_start", bus.req, 1);
    en = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("endrop.hold%0d", k), bus.req, 1);
    end
    bus.ack = 1;
    tick();
    bus.ack = 0;
    chk("endrop.req_end", bus.req, 0);
    chk("endrop.done_cnt", done_cnt, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("endrop.idle%0d", k), bus.req, 0);
    end
    chk("endrop.empty", empty, 0);

    // Never acknowledge: timeout build retires each command after TMO cycles.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      ld = 1; lcmd = 1; laddr = 32'hC0 + i; lwdata = 32'h77;
      tick();
    end
    ld = 0; en = 1; bus.ack = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
`ifdef MASTER_SEQ_TIMEOUT_EN
      exp_req = (k <= 3) || (k >= 5 && k <= 8);
`else
      exp_req = 1'b1;
`endif
      chk($sformatf("tmo.req%0d", k), bus.req, exp_req);
    end
`ifdef MASTER_SEQ_TIMEOUT_EN
    chk("tmo.flag", tmo, 1);
    chk("tmo.done_cnt", done_cnt, 0);
    chk("tmo.empty", empty, 1);
    chk("tmo.rd_valid", rd_valid, 0);
`else
    chk("tmo.flag", tmo, 0);
    bus.ack = 1;
    tick();
    bus.ack = 0;
    chk("tmo.done_cnt", done_cnt, 1);
`endif

    // Randomised traffic against the queue model.
    arst = 1;
    model_update();
    tick();
    compare_all();
    for (int k = 0; k < 3000; k++) begin
      arst      = ($urandom_range(0, 299) == 0);
      ld        = ($urandom_range(0, 2) == 0);
      lcmd      = $urandom_range(0, 1);
      laddr     = $urandom;
      lwdata    = $urandom;
      en        = ($urandom_range(0, 7) != 0);
      bus.ack   = ($urandom_range(0, 2) == 0);
      bus.rdata = $urandom;
      model_update();
      tick();
      compare_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
